// File: rtl/object_feature_reader.sv
`timescale 1ns/1ps
// object_feature_reader: scans the merge table after each frame and emits one record
// (root id, area, floor centroid) for every root label whose data-table area is non-zero.
module object_feature_reader (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [7:0]   num_labels,
  output logic [7:0]   mt_addr,
  input  logic [7:0]   mt_data,
  output logic [7:0]   dt_addr,
  input  logic [383:0] dt_data,
  output logic         obj_valid,
  input  logic         obj_ready,
  output logic [7:0]   obj_id,
  output logic [31:0]  obj_area,
  output logic [31:0]  obj_x,
  output logic [31:0]  obj_y,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, RD_MT, CHK, RD_DT, LATCH, DIV, OUT, DONE} state_e;

  typedef struct packed {
    logic [63:0] quo;
    logic [31:0] rem;
  } div_step_t;

  // One restoring-division step: dividend bits leave the top of quo while quotient
  // bits enter at the bottom, so after 64 steps quo holds the full quotient.
  function automatic div_step_t div_step(input logic [63:0] quo,
                                         input logic [31:0] rem,
                                         input logic [31:0] dvs);
    div_step_t   r;
    logic [32:0] trial;
    logic [32:0] diff;
    trial = {rem, quo[63]};
    diff  = trial - {1'b0, dvs};
    if (trial >= {1'b0, dvs}) begin
      r.rem = diff[31:0];
      r.quo = {quo[62:0], 1'b1};
    end else begin
      r.rem = trial[31:0];
      r.quo = {quo[62:0], 1'b0};
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  l_q, l_d;
  logic [7:0]  mt_addr_q, mt_addr_d;
  logic [7:0]  dt_addr_q, dt_addr_d;
  logic [5:0]  div_cnt_q, div_cnt_d;
  logic [31:0] divisor_q, divisor_d;
  logic [63:0] xnum_q, xnum_d, ynum_q, ynum_d;
  logic [31:0] xrem_q, xrem_d, yrem_q, yrem_d;
  logic [7:0]  obj_id_q, obj_id_d;
  logic [31:0] obj_area_q, obj_area_d;
  logic [31:0] obj_x_q, obj_x_d, obj_y_q, obj_y_d;
  logic        busy_q, done_q;

  div_step_t   x_step, y_step;
  logic        advance;
  logic [7:0]  l_inc;
  logic        unused_dt_bits;

  assign x_step = div_step(xnum_q, xrem_q, divisor_q);
  assign y_step = div_step(ynum_q, yrem_q, divisor_q);
  // Only the low 64 bits of each sum feed the dividers.
  assign unused_dt_bits = ^{dt_data[383:320], dt_data[255:192]};

  always_comb begin
    // NOTE: every next-state variable is given its hold value first, so no path infers a latch.
    state_d    = state_q;
    n_d        = n_q;
    l_d        = l_q;
    mt_addr_d  = mt_addr_q;
    dt_addr_d  = dt_addr_q;
    div_cnt_d  = div_cnt_q;
    divisor_d  = divisor_q;
    xnum_d     = xnum_q;
    ynum_d     = ynum_q;
    xrem_d     = xrem_q;
    yrem_d     = yrem_q;
    obj_id_d   = obj_id_q;
    obj_area_d = obj_area_q;
    obj_x_d    = obj_x_q;
    obj_y_d    = obj_y_q;
    advance    = 1'b0;
    // 8-bit wrap makes L==255 with N==0 (256 labels) terminate like L+1==N.
    l_inc      = l_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d = num_labels;
          l_d = 8'd1;
          if (num_labels == 8'd1) begin
            state_d = DONE;
          end else begin
            state_d   = RD_MT;
            mt_addr_d = 8'd1;
          end
        end
      end
      RD_MT: state_d = CHK;
      CHK: begin
        if (mt_data == l_q) begin
          state_d   = RD_DT;
          dt_addr_d = l_q;
        end else begin
          advance = 1'b1;
        end
      end
      RD_DT: state_d = LATCH;
      LATCH: begin
        if (dt_data[127:0] == 128'd0) begin
          advance = 1'b1;
        end else begin
          divisor_d = (|dt_data[127:32]) ? 32'hFFFF_FFFF : dt_data[31:0];
          xnum_d    = dt_data[191:128];
          ynum_d    = dt_data[319:256];
          xrem_d    = 32'd0;
          yrem_d    = 32'd0;
          div_cnt_d = 6'd0;
          state_d   = DIV;
        end
      end
      DIV: begin
        xnum_d    = x_step.quo;
        xrem_d    = x_step.rem;
        ynum_d    = y_step.quo;
        yrem_d    = y_step.rem;
        div_cnt_d = div_cnt_q + 6'd1;
        if (div_cnt_q == 6'd63) begin
          state_d    = OUT;
          obj_id_d   = l_q;
          obj_area_d = divisor_q;
          obj_x_d    = x_step.quo[31:0];
          obj_y_d    = y_step.quo[31:0];
        end
      end
      OUT: begin
        if (obj_ready) advance = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (l_inc == n_q) begin
        state_d = DONE;
      end else begin
        l_d       = l_inc;
        mt_addr_d = l_inc;
        state_d   = RD_MT;
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      n_q        <= 8'd0;
      l_q        <= 8'd1;
      mt_addr_q  <= 8'd0;
      dt_addr_q  <= 8'd0;
      obj_id_q   <= 8'd0;
      obj_area_q <= 32'd0;
      obj_x_q    <= 32'd0;
      obj_y_q    <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      l_q        <= l_d;
      mt_addr_q  <= mt_addr_d;
      dt_addr_q  <= dt_addr_d;
      obj_id_q   <= obj_id_d;
      obj_area_q <= obj_area_d;
      obj_x_q    <= obj_x_d;
      obj_y_q    <= obj_y_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_q == DONE);
    end
  end

  // NOTE: the divider datapath has no reset; LATCH always loads it before DIV reads it.
  always_ff @(posedge clk) begin
    div_cnt_q <= div_cnt_d;
    divisor_q <= divisor_d;
    xnum_q    <= xnum_d;
    ynum_q    <= ynum_d;
    xrem_q    <= xrem_d;
    yrem_q    <= yrem_d;
  end

  assign mt_addr   = mt_addr_q;
  assign dt_addr   = dt_addr_q;
  assign obj_valid = (state_q == OUT);
  assign obj_id    = obj_id_q;
  assign obj_area  = obj_area_q;
  assign obj_x     = obj_x_q;
  assign obj_y     = obj_y_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_object_feature_reader.sv
`timescale 1ns/1ps
// Directed bench for object_feature_reader: table models with 1-cycle read latency,
// a record/done monitor and hand-computed expectations.
module tb_object_feature_reader;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [7:0]   num_labels;
  logic [7:0]   mt_addr;
  logic [7:0]   mt_data;
  logic [7:0]   dt_addr;
  logic [383:0] dt_data;
  logic         obj_valid;
  logic         obj_ready;
  logic [7:0]   obj_id;
  logic [31:0]  obj_area;
  logic [31:0]  obj_x;
  logic [31:0]  obj_y;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  object_feature_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .num_labels (num_labels),
    .mt_addr    (mt_addr),
    .mt_data    (mt_data),
    .dt_addr    (dt_addr),
    .dt_data    (dt_data),
    .obj_valid  (obj_valid),
    .obj_ready  (obj_ready),
    .obj_id     (obj_id),
    .obj_area   (obj_area),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .busy       (busy),
    .done       (done)
  );

  logic [7:0]   mt_mem [256];
  logic [383:0] dt_mem [256];

  always @(posedge clk) begin
    mt_data <= mt_mem[mt_addr];
    dt_data <= dt_mem[dt_addr];
  end

  typedef struct {
    logic [7:0]  id;
    logic [31:0] area;
    logic [31:0] x;
    logic [31:0] y;
  } rec_t;

  rec_t       recs[$];
  int         done_cnt;
  bit         mt_seen [256];
  bit         dt_seen [256];
  logic [7:0] mt_prev, dt_prev;
  int         checks   = 0;
  int         failures = 0;

  always @(negedge clk) begin : monitor
    rec_t r;
    if (obj_valid && obj_ready) begin
      r.id = obj_id; r.area = obj_area; r.x = obj_x; r.y = obj_y;
      recs.push_back(r);
    end
    if (done) done_cnt++;
    if (mt_addr != mt_prev) mt_seen[mt_addr] = 1'b1;
    if (dt_addr != dt_prev) dt_seen[dt_addr] = 1'b1;
    mt_prev = mt_addr;
    dt_prev = dt_addr;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_clear();
    for (int i = 0; i < 256; i++) begin
      mt_mem[i] = 8'd0;
      dt_mem[i] = '0;
    end
  endtask

  function automatic logic [383:0] dt_word(input logic [127:0] sy, input logic [127:0] sx,
                                           input logic [127:0] ar);
    return {sy, sx, ar};
  endfunction

  task automatic clear_tracking();
    recs.delete();
    done_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      mt_seen[i] = 1'b0;
      dt_seen[i] = 1'b0;
    end
    mt_prev = mt_addr;
    dt_prev = dt_addr;
  endtask

  task automatic do_start(input logic [7:0] n);
    num_labels = n;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin
      step();
      c++;
    end
    check({tag, "_done_in_time"}, 64'(done_cnt != 0), 64'd1);
    repeat (2) step();
  endtask

  task automatic check_rec(input string tag, input int idx, input logic [7:0] id,
                           input logic [31:0] area, input logic [31:0] x, input logic [31:0] y);
    if (idx >= recs.size()) begin
      check({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_id"},   64'(recs[idx].id),   64'(id));
      check({tag, "_area"}, 64'(recs[idx].area), 64'(area));
      check({tag, "_x"},    64'(recs[idx].x),    64'(x));
      check({tag, "_y"},    64'(recs[idx].y),    64'(y));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_obj_valid"}, 64'(obj_valid), 64'd0);
    check({tag, "_obj_id"},    64'(obj_id),    64'd0);
    check({tag, "_obj_area"},  64'(obj_area),  64'd0);
    check({tag, "_obj_x"},     64'(obj_x),     64'd0);
    check({tag, "_obj_y"},     64'(obj_y),     64'd0);
    check({tag, "_mt_addr"},   64'(mt_addr),   64'd0);
    check({tag, "_dt_addr"},   64'(dt_addr),   64'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int lat;
    int err;
    int c;
    int done_at;
    int busy_cycles;
    logic [7:0]  s_id;
    logic [31:0] s_area, s_x, s_y;

    reset_n    = 1'b0;
    start      = 1'b0;
    num_labels = 8'd0;
    obj_ready  = 1'b1;
    mem_clear();
    done_cnt   = 0;
    mt_prev    = 8'd0;
    dt_prev    = 8'd0;
    repeat (3) step();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    step();

    // Basic scan: roots 1 and 3, label 2 merges into 1.
    mem_clear();
    mt_mem[1] = 8'd1; mt_mem[2] = 8'd1; mt_mem[3] = 8'd3;
    dt_mem[1] = dt_word(128'd40, 128'd60, 128'd10);
    dt_mem[2] = dt_word(128'd99, 128'd99, 128'd9);
    dt_mem[3] = dt_word(128'd7, 128'd21, 128'd7);
    clear_tracking();
    do_start(8'd4);
    check("a_busy_after_start", 64'(busy), 64'd1);
    lat = 0;
    while (!obj_valid && lat < 200) begin
      step();
      lat++;
    end
    check("a_latency", 64'(lat), 64'd68);
    wait_done("a", 1000);
    check("a_nrec", 64'(recs.size()), 64'd2);
    check_rec("a_r0", 0, 8'd1, 32'd10, 32'd6, 32'd4);
    check_rec("a_r1", 1, 8'd3, 32'd7, 32'd3, 32'd1);
    check("a_done_cnt", 64'(done_cnt), 64'd1);
    check("a_dt2_unread", 64'(dt_seen[2]), 64'd0);
    check("a_busy_end", 64'(busy), 64'd0);

    // Area saturation, 64-bit sum truncation and 32-bit quotient truncation.
    mem_clear();
    mt_mem[1] = 8'd1; mt_mem[2] = 8'd2;
    dt_mem[1] = dt_word(128'd5, {64'hDEAD_BEEF_0000_0001, 64'h0000_0002_FFFF_FFFE},
                        128'h1_0000_0000);
    dt_mem[2] = dt_word({64'h1234, 64'hFFFF_FFFF_FFFF_FFFF},
                        {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0007}, 128'd1);
    clear_tracking();
    do_start(8'd3);
    wait_done("b", 1000);
    check("b_nrec", 64'(recs.size()), 64'd2);
    check_rec("b_r0", 0, 8'd1, 32'hFFFF_FFFF, 32'd3, 32'd0);
    check_rec("b_r1", 1, 8'd2, 32'd1, 32'd7, 32'hFFFF_FFFF);

    // Non-roots 1..4, root 5 with zero area, root 6 held by back-pressure.
    mem_clear();
    mt_mem[5] = 8'd5; dt_mem[5] = dt_word(128'd99, 128'd99, 128'd0);
    mt_mem[6] = 8'd6; dt_mem[6] = dt_word(128'd20, 128'd10, 128'd3);
    obj_ready = 1'b0;
    clear_tracking();
    do_start(8'd7);
    c = 0;
    while (!obj_valid && c < 500) begin
      step();
      c++;
    end
    check("c_valid_seen", 64'(obj_valid), 64'd1);
    s_id = obj_id; s_area = obj_area; s_x = obj_x; s_y = obj_y;
    err = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obj_valid !== 1'b1 || obj_id !== s_id || obj_area !== s_area ||
          obj_x !== s_x || obj_y !== s_y) err++;
    end
    check("c_stable_while_stalled", 64'(err), 64'd0);
    check("c_no_rec_while_stalled", 64'(recs.size()), 64'd0);
    obj_ready = 1'b1;
    step();
    check("c_valid_drops_after_accept", 64'(obj_valid), 64'd0);
    wait_done("c", 500);
    check("c_nrec", 64'(recs.size()), 64'd1);
    check_rec("c_r0", 0, 8'd6, 32'd3, 32'd3, 32'd6);
    check("c_dt5_read", 64'(dt_seen[5]), 64'd1);

    // N==1: empty scan.
    clear_tracking();
    do_start(8'd1);
    done_at     = 0;
    busy_cycles = 0;
    for (int i = 1; i <= 6; i++) begin
      if (done && done_at == 0) done_at = i;
      if (busy) busy_cycles++;
      step();
    end
    check("d_done_delay", 64'(done_at), 64'd2);
    check("d_busy_cycles", 64'(busy_cycles), 64'd1);
    check("d_nrec", 64'(recs.size()), 64'd0);
    check("d_done_cnt", 64'(done_cnt), 64'd1);

    // N==0: all 255 labels are roots with area 1.
    mem_clear();
    for (int i = 1; i < 256; i++) begin
      mt_mem[i] = 8'(i);
      dt_mem[i] = dt_word(128'(2 * i), 128'(i), 128'd1);
    end
    clear_tracking();
    do_start(8'd0);
    wait_done("e", 30000);
    check("e_nrec", 64'(recs.size()), 64'd255);
    err = 0;
    for (int i = 0; i < recs.size(); i++) begin
      if (recs[i].id !== 8'(i + 1) || recs[i].area !== 32'd1 ||
          recs[i].x !== 32'(i + 1) || recs[i].y !== 32'(2 * (i + 1))) err++;
    end
    check("e_record_errors", 64'(err), 64'd0);
    check("e_mt0_untouched", 64'(mt_seen[0]), 64'd0);
    check("e_dt0_untouched", 64'(dt_seen[0]), 64'd0);
    check("e_mt255_read", 64'(mt_seen[255]), 64'd1);
    check("e_done_cnt", 64'(done_cnt), 64'd1);

    // Reset during the divide of label 2, then a clean rescan.
    mem_clear();
    for (int i = 1; i < 4; i++) begin
      mt_mem[i] = 8'(i);
      dt_mem[i] = dt_word(128'd4, 128'd8, 128'd2);
    end
    clear_tracking();
    do_start(8'd4);
    c = 0;
    while (dt_addr != 8'd2 && c < 500) begin
      step();
      c++;
    end
    check("f_reached_label2", 64'(dt_addr), 64'd2);
    repeat (10) step();
    reset_n = 1'b0;
    step();
    check_idle_outputs("f_rst");
    reset_n = 1'b1;
    repeat (5) step();
    check("f_no_done_after_abort", 64'(done_cnt), 64'd0);
    check("f_idle_after_abort", 64'(busy), 64'd0);
    clear_tracking();
    do_start(8'd4);
    wait_done("f", 1000);
    check("f_nrec", 64'(recs.size()), 64'd3);
    check_rec("f_r0", 0, 8'd1, 32'd2, 32'd4, 32'd2);
    check_rec("f_r2", 2, 8'd3, 32'd2, 32'd4, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
